// File: rtl/uart_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : DataTypes (package)
//  Description : Shared types and frame constants for the UART receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package DataTypes;

    typedef logic       bit_t;
    typedef logic [7:0] uint8_t;

    // Receiver FSM states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 11;

    // Even parity of a byte: the parity bit a well-formed frame must carry
    function automatic bit_t even_parity(input uint8_t d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_receiver_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fsm
//  Description : State register and next-state / control decode for the UART
//                receiver. Emits timer, bit-counter, shift and capture
//                controls to the datapath in uart_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
    import DataTypes::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rx_s_i,
    input  logic timer_expired_i,
    input  logic last_bit_i,
    output logic busy_o,
    output logic load_half_o,
    output logic load_full_o,
    output logic clr_cnt_o,
    output logic cnt_inc_o,
    output logic shift_o,
    output logic cap_parity_o,
    output logic cap_frame_o
);

    uart_rx_state_t state_q, state_d;

    // State register; reset aborts any frame in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d      = state_q;
        busy_o       = (state_q != IDLE);
        load_half_o  = 1'b0;
        load_full_o  = 1'b0;
        clr_cnt_o    = 1'b0;
        cnt_inc_o    = 1'b0;
        shift_o      = 1'b0;
        cap_parity_o = 1'b0;
        cap_frame_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_i) begin
                    state_d     = START;
                    load_half_o = 1'b1;
                end
            end
            START: begin
                if (timer_expired_i) begin
                    if (!rx_s_i) begin
                        state_d     = DATA;
                        load_full_o = 1'b1;
                        clr_cnt_o   = 1'b1;
                    end else begin
                        // Line back high at mid-start: treat as a glitch
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (timer_expired_i) begin
                    shift_o     = 1'b1;
                    load_full_o = 1'b1;
                    if (last_bit_i) state_d   = PARITY;
                    else            cnt_inc_o = 1'b1;
                end
            end
            PARITY: begin
                if (timer_expired_i) begin
                    cap_parity_o = 1'b1;
                    load_full_o  = 1'b1;
                    state_d      = STOP;
                end
            end
            STOP: begin
                if (timer_expired_i) begin
                    cap_frame_o = 1'b1;
                    state_d     = rx_s_i ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // Broken stop bit: do not hunt for a start edge until line idles
                if (rx_s_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : UART receiver for 11-bit frames (start, 8 data MSB first,
//                even parity, stop). Mid-bit sampling via a bit timer; the
//                byte and error flags are presented with a one-cycle strobe.
//                Optional macro UART_RX_PARITY_CHECK_EN enables parity
//                checking; otherwise the parity slot is consumed and ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import DataTypes::*;
#(
    parameter int BIT_PERIOD = 434
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   serial_input_rx,
    output uint8_t rx_data,
    output logic   data_valid,
    output logic   parity_error,
    output logic   framing_error,
    output logic   busy
);

    localparam int TW = $clog2(BIT_PERIOD + 1);
    localparam logic [TW-1:0] HALF_PERIOD = TW'(BIT_PERIOD / 2);
    localparam logic [TW-1:0] FULL_PERIOD = TW'(BIT_PERIOD);
    localparam logic [2:0]    LAST_BIT    = 3'(UART_DATA_BITS - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    uint8_t        shift_q, shift_d;
    uint8_t        rx_data_q, rx_data_d;
    logic          data_valid_q, data_valid_d;
    logic          parity_error_q, parity_error_d;
    logic          framing_error_q, framing_error_d;

    logic timer_expired, last_bit;
    logic load_half, load_full, clr_cnt, cnt_inc, shift_en, cap_parity, cap_frame;

    assign rx_s          = sync_q[1];
    assign timer_expired = (timer_q == TW'(1));
    assign last_bit      = (bit_cnt_q == LAST_BIT);

    uart_rx_fsm u_fsm (
        .clk             (clk),
        .reset           (reset),
        .rx_s_i          (rx_s),
        .timer_expired_i (timer_expired),
        .last_bit_i      (last_bit),
        .busy_o          (busy),
        .load_half_o     (load_half),
        .load_full_o     (load_full),
        .clr_cnt_o       (clr_cnt),
        .cnt_inc_o       (cnt_inc),
        .shift_o         (shift_en),
        .cap_parity_o    (cap_parity),
        .cap_frame_o     (cap_frame)
    );

`ifdef UART_RX_PARITY_CHECK_EN
    logic parity_q;

    // Hold the received parity bit until the stop sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          parity_q <= 1'b0;
        else if (cap_parity) parity_q <= rx_s;
    end

    assign parity_error_d = cap_frame ? (parity_q != even_parity(shift_q)) : parity_error_q;
`else
    // Parity slot is timed by the FSM but its value is discarded
    logic unused_cap_parity;
    assign unused_cap_parity = cap_parity;
    assign parity_error_d    = 1'b0;
`endif

    // Datapath next-state: timer, bit counter, shifter and output capture
    always_comb begin
        timer_d = timer_q;
        if (load_half)              timer_d = HALF_PERIOD;
        else if (load_full)         timer_d = FULL_PERIOD;
        else if (timer_q != '0)     timer_d = timer_q - 1'b1;

        bit_cnt_d = bit_cnt_q;
        if (clr_cnt)      bit_cnt_d = 3'd0;
        else if (cnt_inc) bit_cnt_d = bit_cnt_q + 3'd1;

        // First received bit ends up in bit 7 (MSB-first line order)
        shift_d = shift_en ? {shift_q[6:0], rx_s} : shift_q;

        rx_data_d       = cap_frame ? shift_q : rx_data_q;
        framing_error_d = cap_frame ? ~rx_s   : framing_error_q;
        data_valid_d    = cap_frame;
    end

    // Synchronizer and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q          <= 2'b11;
            timer_q         <= '0;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'h00;
            rx_data_q       <= 8'h00;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            sync_q          <= {sync_q[0], serial_input_rx};
            timer_q         <= timer_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            rx_data_q       <= rx_data_d;
            data_valid_q    <= data_valid_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_valid    = data_valid_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver (BIT_PERIOD = 16).
//                Directed frames are driven on the serial line; expected
//                bytes/flags are queued and checked on each data_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int BP = 16;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    int   checks    = 0;
    int   errors    = 0;
    int   n_strobes = 0;
    int   cyc       = 0;
    int   last_dv_cyc = 0;
    int   prev_dv_cyc = 0;
    logic dv_prev   = 1'b0;
    exp_t sb[$];

    uart_receiver #(.BIT_PERIOD(BP)) dut (
        .clk             (clk),
        .reset           (reset),
        .serial_input_rx (rx),
        .rx_data         (rx_data),
        .data_valid      (data_valid),
        .parity_error    (parity_error),
        .framing_error   (framing_error),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (data_valid) begin
            exp_t e;
            n_strobes++;
            prev_dv_cyc = last_dv_cyc;
            last_dv_cyc = cyc;
            chk("dv_one_cycle", {31'd0, dv_prev}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                chk("parity_error", {31'd0, parity_error}, {31'd0, e.perr});
                chk("framing_error", {31'd0, framing_error}, {31'd0, e.ferr});
            end
        end
        dv_prev = data_valid;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BP) @(negedge clk);
    endtask

    // Drive one full frame and queue what the receiver must report for it
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.data = d;
`ifdef UART_RX_PARITY_CHECK_EN
        e.perr = (par != ^d);
`else
        e.perr = 1'b0;
`endif
        e.ferr = ~stp;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_parity_error", {31'd0, parity_error}, 32'd0);
        chk("rst_framing_error", {31'd0, framing_error}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Clean frame
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("a5_strobes", n_strobes, 32'd1);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);
        drive_bit(1'b1);

        // Wrong parity bit
        send_frame(8'h01, 1'b0, 1'b1);
        chk("p01_strobes", n_strobes, 32'd2);
        drive_bit(1'b1);

        // Broken stop bit, line held low afterwards
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        chk("3c_busy_wait_high", {31'd0, busy}, 32'd1);
        chk("3c_strobes", n_strobes, 32'd3);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("3c_busy_released", {31'd0, busy}, 32'd0);
        drive_bit(1'b1);

        // Short low glitch rejected at mid-start
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_during", {31'd0, busy}, 32'd1);
        repeat (15) @(negedge clk);
        chk("glitch_busy_after", {31'd0, busy}, 32'd0);
        chk("glitch_strobes", n_strobes, 32'd3);
        chk("glitch_rx_data_hold", {24'd0, rx_data}, 32'h3C);
        chk("glitch_ferr_hold", {31'd0, framing_error}, 32'd1);
        drive_bit(1'b1);

        // Back-to-back frames, no idle gap
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        chk("b2b_strobes", n_strobes, 32'd5);
        chk("b2b_spacing", last_dv_cyc - prev_dv_cyc, 11 * BP);
        drive_bit(1'b1);

        // Reset during data bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (BP / 2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("mid_rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("mid_rst_parity_error", {31'd0, parity_error}, 32'd0);
        chk("mid_rst_framing_error", {31'd0, framing_error}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_strobes", n_strobes, 32'd5);

        // Fresh frame after reset
        send_frame(8'h12, 1'b0, 1'b1);
        chk("p12_strobes", n_strobes, 32'd6);
        drive_bit(1'b1);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
